// File: rtl/cl_capture_ctrl.sv
// rtl/cl_capture_ctrl.sv - Camera Link frame capture controller
//
// Purpose: arms on command, aligns to a clean frame start, gates valid pixels
// onto a registered stream with start-of-frame / end-of-line marking, and
// measures frame geometry against configured values.
//
// Ports:
//   CL_clk, CL_rst        pixel clock, synchronous active-high reset
//   CL_data[27:0]         [23:0] pixel, [24] lval, [25] fval, [26] dval, [27] spare
//   cfg_start, cfg_stop   one-cycle arm / stop pulses
//   cfg_continuous        re-arm after each frame
//   cfg_width, cfg_height expected geometry, 0 disables the check
//   m_tdata/tvalid/tuser/tlast, m_tready   pixel stream (never stalls)
//   st_busy, st_frame_done, st_frame_cnt, st_width, st_height,
//   st_err_width, st_err_height, st_overflow   status
module cl_capture_ctrl #(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic              CL_clk,
  input  logic              CL_rst,
  input  logic [27:0]       CL_data,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              cfg_continuous,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [CNT_W-1:0]  cfg_height,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tuser,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              st_busy,
  output logic              st_frame_done,
  output logic [CNT_W-1:0]  st_frame_cnt,
  output logic [CNT_W-1:0]  st_width,
  output logic [CNT_W-1:0]  st_height,
  output logic              st_err_width,
  output logic              st_err_height,
  output logic              st_overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOW, S_WAIT_HIGH, S_CAPTURE, S_END
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] s1_pix;
  logic              s1_fval, s1_lval, s1_dval;
  logic              fv_prev, lv_prev;
  logic [DATA_W-1:0] h_data;
  logic              h_sof, h_full;
  logic              sof_pend, stop_pend;
  logic [CNT_W-1:0]  pix_cnt, line_cnt, last_w;

  logic              pix_vld, fv_rise, fv_fall, lv_fall, cap_act, line_end;
  logic              arm_ok;
  logic [CNT_W-1:0]  line_cnt_nxt, width_nxt;

  logic unused_spare;
  assign unused_spare = CL_data[27];

  assign pix_vld = s1_fval & s1_lval & s1_dval;
  assign fv_rise = s1_fval & ~fv_prev;
  assign fv_fall = ~s1_fval & fv_prev;
  // A frame end also closes any line still open.
  assign lv_fall = (~s1_lval & lv_prev) | fv_fall;
  // WAIT_HIGH is included so a pixel coincident with the fval rise is kept;
  // fval is low there otherwise, so no pixel can leak in early.
  assign cap_act = (state == S_CAPTURE) || (state == S_WAIT_HIGH);
  // Only non-empty lines count; an fval fall after lval already fell is not a line.
  assign line_end = cap_act & lv_fall & (pix_cnt != '0);
  assign line_cnt_nxt = line_cnt + (line_end ? CNT_W'(1) : CNT_W'(0));
  assign width_nxt    = line_end ? pix_cnt : last_w;
  assign arm_ok       = (state == S_IDLE) && cfg_start && !cfg_stop;
  assign st_busy      = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (arm_ok) state_nxt = S_WAIT_LOW;
      S_WAIT_LOW:  if (cfg_stop) state_nxt = S_IDLE;
                   else if (!s1_fval) state_nxt = S_WAIT_HIGH;
      S_WAIT_HIGH: if (cfg_stop) state_nxt = S_IDLE;
                   else if (fv_rise) state_nxt = S_CAPTURE;
      S_CAPTURE:   if (fv_fall) state_nxt = S_END;
      S_END:       state_nxt = (cfg_continuous && !stop_pend && !cfg_stop) ? S_WAIT_HIGH : S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CL_clk) begin
    if (CL_rst) begin
      state         <= S_IDLE;
      s1_pix        <= '0;
      s1_fval       <= 1'b0;
      s1_lval       <= 1'b0;
      s1_dval       <= 1'b0;
      fv_prev       <= 1'b0;
      lv_prev       <= 1'b0;
      h_data        <= '0;
      h_sof         <= 1'b0;
      h_full        <= 1'b0;
      sof_pend      <= 1'b0;
      stop_pend     <= 1'b0;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      last_w        <= '0;
      m_tdata       <= '0;
      m_tvalid      <= 1'b0;
      m_tuser       <= 1'b0;
      m_tlast       <= 1'b0;
      st_frame_done <= 1'b0;
      st_frame_cnt  <= '0;
      st_width      <= '0;
      st_height     <= '0;
      st_err_width  <= 1'b0;
      st_err_height <= 1'b0;
      st_overflow   <= 1'b0;
    end else begin
      state   <= state_nxt;
      s1_pix  <= CL_data[DATA_W-1:0];
      s1_lval <= CL_data[24];
      s1_fval <= CL_data[25];
      s1_dval <= CL_data[26];
      fv_prev <= s1_fval;
      lv_prev <= s1_lval;

      m_tvalid      <= 1'b0;
      m_tuser       <= 1'b0;
      m_tlast       <= 1'b0;
      st_frame_done <= 1'b0;

      if (state_nxt == S_IDLE) stop_pend <= 1'b0;
      else if (state == S_CAPTURE && cfg_stop) stop_pend <= 1'b1;

      if (arm_ok) begin
        st_err_width  <= 1'b0;
        st_err_height <= 1'b0;
        st_overflow   <= 1'b0;
      end else if (m_tvalid && !m_tready) begin
        st_overflow <= 1'b1;
      end

      if (!cap_act) h_full <= 1'b0;

      // Outside a frame the per-frame counters idle cleared, ready for the next sof.
      if (state == S_IDLE || state == S_WAIT_LOW || state == S_END) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
        last_w   <= '0;
        sof_pend <= 1'b1;
      end

      if (cap_act) begin
        if (pix_vld) begin
          if (h_full) begin
            m_tdata  <= h_data;
            m_tvalid <= 1'b1;
            m_tuser  <= h_sof;
          end
          h_data   <= s1_pix;
          h_sof    <= sof_pend;
          h_full   <= 1'b1;
          sof_pend <= 1'b0;
          if (pix_cnt != '1) pix_cnt <= pix_cnt + CNT_W'(1);
        end else if (lv_fall && h_full) begin
          m_tdata  <= h_data;
          m_tvalid <= 1'b1;
          m_tuser  <= h_sof;
          m_tlast  <= 1'b1;
          h_full   <= 1'b0;
        end
        if (line_end) begin
          pix_cnt  <= '0;
          line_cnt <= line_cnt_nxt;
          last_w   <= pix_cnt;
          if (cfg_width != '0 && pix_cnt != cfg_width) st_err_width <= 1'b1;
        end
      end

      // Status is latched on the edge into END so it is already valid while
      // st_frame_done is high; the *_nxt terms fold in a line closing on this edge.
      if (state == S_CAPTURE && fv_fall) begin
        st_frame_done <= 1'b1;
        st_frame_cnt  <= st_frame_cnt + CNT_W'(1);
        st_width      <= width_nxt;
        st_height     <= line_cnt_nxt;
        if (cfg_height != '0 && line_cnt_nxt != cfg_height) st_err_height <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cl_capture_ctrl.sv
// tb/tb_cl_capture_ctrl.sv - directed self-checking bench for cl_capture_ctrl
module tb_cl_capture_ctrl;
  localparam int DATA_W = 24;
  localparam int CNT_W  = 16;
  localparam logic [23:0] NONE = 24'hFFFFFF;

  logic              CL_clk = 1'b0;
  logic              CL_rst = 1'b1;
  logic [27:0]       CL_data = '0;
  logic              cfg_start = 1'b0, cfg_stop = 1'b0, cfg_continuous = 1'b0;
  logic [CNT_W-1:0]  cfg_width = '0, cfg_height = '0;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid, m_tuser, m_tlast;
  logic              m_tready = 1'b1;
  logic              st_busy, st_frame_done;
  logic [CNT_W-1:0]  st_frame_cnt, st_width, st_height;
  logic              st_err_width, st_err_height, st_overflow;

  cl_capture_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CL_clk(CL_clk), .CL_rst(CL_rst), .CL_data(CL_data),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_continuous(cfg_continuous),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .st_busy(st_busy), .st_frame_done(st_frame_done), .st_frame_cnt(st_frame_cnt),
    .st_width(st_width), .st_height(st_height),
    .st_err_width(st_err_width), .st_err_height(st_err_height), .st_overflow(st_overflow)
  );

  always #5 CL_clk = ~CL_clk;

  int cyc = 0;
  always @(posedge CL_clk) cyc <= cyc + 1;

  // observed beats and frame_done pulses
  logic [23:0] bq_data[$];
  logic        bq_user[$], bq_last[$];
  int          bq_cyc[$];
  int          done_cnt = 0;

  always @(negedge CL_clk) begin
    if (m_tvalid === 1'b1) begin
      bq_data.push_back(m_tdata);
      bq_user.push_back(m_tuser);
      bq_last.push_back(m_tlast);
      bq_cyc.push_back(cyc);
    end
    if (st_frame_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // expected beats, built from the stimulus
  logic [23:0] ex_data[$];
  logic        ex_user[$], ex_last[$];
  int          ex_cyc[$];
  bit          rec = 1'b0, first_pend = 1'b0;
  logic [23:0] arm_px = NONE, stop_px = NONE, stall_px = NONE;
  int          stall_cyc = -1;

  int n_cmp = 0, n_err = 0;
  int b0, e0, d0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic fv, input logic lv, input logic dv, input logic [23:0] px, input logic lst);
    bit v;
    @(posedge CL_clk); #1;
    v = fv && lv && dv;
    CL_data   = {1'b0, dv, fv, lv, px};
    cfg_start = v && (px == arm_px);
    cfg_stop  = v && (px == stop_px);
    if (v && rec) begin
      ex_data.push_back(px);
      ex_user.push_back(first_pend);
      ex_last.push_back(lst);
      ex_cyc.push_back(cyc);
      first_pend = 1'b0;
      if (px == stall_px) stall_cyc = cyc + 3;
    end
    m_tready = (cyc != stall_cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic pulse(input logic s, input logic p);
    @(posedge CL_clk); #1;
    CL_data = '0; cfg_start = s; cfg_stop = p; m_tready = 1'b1;
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic drive_line(input int n, input int base, input int gap_at, input int gap_len);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) repeat (gap_len) step(1'b1, 1'b1, 1'b0, 24'h5A5A5A, 1'b0);
      step(1'b1, 1'b1, 1'b1, 24'(base + i), i == n - 1);
    end
    repeat (4) step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic frame_open();
    first_pend = 1'b1;
    idle(4);
    repeat (2) step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic drive_frame(input int nl, input int w, input int base);
    frame_open();
    for (int l = 0; l < nl; l++) drive_line(w, base + l * w, -1, 0);
    idle(4);
  endtask

  task automatic check_beats(input int nexp, input bit lat);
    int nb, ne;
    nb = bq_data.size() - b0;
    ne = ex_data.size() - e0;
    check("beat_count", nb, nexp);
    check("exp_count", ne, nexp);
    for (int i = 0; i < nb && i < ne; i++) begin
      check("beat_data", bq_data[b0+i], ex_data[e0+i]);
      check("beat_tuser", bq_user[b0+i], ex_user[e0+i]);
      check("beat_tlast", bq_last[b0+i], ex_last[e0+i]);
      if (lat) check("beat_latency", bq_cyc[b0+i] - ex_cyc[e0+i], 3);
    end
  endtask

  task automatic mark();
    b0 = bq_data.size(); e0 = ex_data.size(); d0 = done_cnt;
  endtask

  initial begin
    // reset with a live frame on the input
    for (int i = 0; i < 2; i++) begin
      @(posedge CL_clk); #1;
      CL_data = {1'b0, 1'b1, 1'b1, i[0], 24'hC0FFEE ^ 24'(i * 24'h111111)};
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_flags", {m_tuser, m_tlast, st_busy, st_frame_done}, 0);
      check("rst_counts", {st_frame_cnt, st_width}, 0);
      check("rst_status", {st_height, st_err_width, st_err_height, st_overflow}, 0);
    end
    CL_rst = 1'b0;
    mark();
    idle(6);
    check("rst_busy_after", st_busy, 0);
    check("rst_no_beats", bq_data.size() - b0, 0);

    // single frame 3x8
    cfg_width = 16'd8; cfg_height = 16'd3;
    mark(); rec = 1'b1;
    pulse(1'b1, 1'b0);
    check("arm_busy", st_busy, 1);
    drive_frame(3, 8, 1);
    idle(3);
    check_beats(24, 1'b1);
    check("sf_done", done_cnt - d0, 1);
    check("sf_width", st_width, 8);
    check("sf_height", st_height, 3);
    check("sf_frame_cnt", st_frame_cnt, 1);
    check("sf_errs", {st_err_width, st_err_height, st_overflow}, 0);
    check("sf_busy", st_busy, 0);

    // arm in the middle of a frame: only the following frame is captured
    mark(); rec = 1'b0; arm_px = 24'd12;
    drive_frame(3, 8, 1);
    arm_px = NONE; rec = 1'b1;
    check("mid_no_beats", bq_data.size() - b0, 0);
    check("mid_busy", st_busy, 1);
    drive_frame(3, 8, 101);
    idle(3);
    check_beats(24, 1'b1);
    check("mid_frame_cnt", st_frame_cnt, 2);

    // geometry errors and dval gaps
    mark();
    pulse(1'b1, 1'b0);
    frame_open();
    drive_line(8, 201, -1, 0);
    drive_line(7, 209, 3, 3);
    idle(4);
    idle(3);
    check_beats(15, 1'b0);
    check("geo_err_width", st_err_width, 1);
    check("geo_err_height", st_err_height, 1);
    check("geo_height", st_height, 2);
    check("geo_width", st_width, 7);
    check("geo_frame_cnt", st_frame_cnt, 3);

    // backpressure on one beat
    mark();
    pulse(1'b1, 1'b0);
    check("bp_sticky_clear", {st_err_width, st_err_height}, 0);
    stall_px = 24'd5;
    drive_frame(3, 8, 1);
    stall_px = NONE;
    idle(3);
    check_beats(24, 1'b1);
    check("bp_overflow", st_overflow, 1);
    check("bp_frame_cnt", st_frame_cnt, 4);
    pulse(1'b1, 1'b0);
    idle(1);
    check("bp_overflow_clr", st_overflow, 0);
    pulse(1'b0, 1'b1);
    idle(2);
    check("bp_stop_idle", st_busy, 0);

    // continuous capture, stop during the second frame
    cfg_continuous = 1'b1;
    mark();
    pulse(1'b1, 1'b0);
    drive_frame(3, 8, 1);
    check("cont_busy_between", st_busy, 1);
    check("cont_done1", done_cnt - d0, 1);
    stop_px = 24'd112;
    drive_frame(3, 8, 101);
    stop_px = NONE;
    idle(3);
    check_beats(48, 1'b1);
    check("cont_done2", done_cnt - d0, 2);
    check("cont_frame_cnt", st_frame_cnt, 6);
    check("cont_busy_end", st_busy, 0);

    // start and stop together: stays idle
    mark(); rec = 1'b0;
    pulse(1'b1, 1'b1);
    idle(2);
    check("ss_busy", st_busy, 0);
    drive_frame(3, 8, 1);
    idle(3);
    check("ss_no_beats", bq_data.size() - b0, 0);
    check("ss_frame_cnt", st_frame_cnt, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cl_capture_ctrl.md
# cl_capture_ctrl

Frame capture controller for the Camera Link receive path. It sits on the `CL_clk` domain after the `CLReceive` deserializer and consumes its 28-bit parallel word. It arms on command, aligns to a clean frame start, and gates valid pixels onto a stream output with start-of-frame and end-of-line marking. It measures frame geometry against configured values and reports status to software.

## Interface
- `DATA_W`, 24: pixel field width, `CL_data[DATA_W-1:0]`.
- `CNT_W`, 16: width of pixel, line and frame counters.

- `CL_clk`, in, 1: Camera Link pixel clock; the only clock.
- `CL_rst`, in, 1: synchronous, active-high reset.
- `CL_data`, in, 28: `[23:0]` pixel, `[24]` lval, `[25]` fval, `[26]` dval, `[27]` spare (ignored).
- `cfg_start`, in, 1: one-cycle arm pulse.
- `cfg_stop`, in, 1: one-cycle stop pulse.
- `cfg_continuous`, in, 1: 1 = re-arm after each frame; 0 = single frame.
- `cfg_width`, in, CNT_W: expected pixels per line; 0 disables the check.
- `cfg_height`, in, CNT_W: expected lines per frame; 0 disables the check.
- `m_tdata`, out, DATA_W: pixel out.
- `m_tvalid`, out, 1: one-cycle beat strobe.
- `m_tuser`, out, 1: first pixel of the frame.
- `m_tlast`, out, 1: last pixel of a line.
- `m_tready`, in, 1: sink ready; the block never stalls.
- `st_busy`, out, 1: state is not IDLE.
- `st_frame_done`, out, 1: one-cycle pulse at end of each captured frame.
- `st_frame_cnt`, out, CNT_W: completed frames since reset; wraps.
- `st_width`, out, CNT_W: pixel count of the last line of the last frame.
- `st_height`, out, CNT_W: line count of the last frame.
- `st_err_width`, out, 1: sticky; any line length ≠ `cfg_width`.
- `st_err_height`, out, 1: sticky; frame height ≠ `cfg_height`.
- `st_overflow`, out, 1: sticky; a beat was emitted with `m_tready`=0.

## Operation
- Stage S1 registers `CL_data`. A pixel is valid when S1 fval, lval and dval are all 1.
- Edge detects on S1 fval and lval use the previous S1 value.
- FSM states and transitions:
  - IDLE: `cfg_start` moves to WAIT_FV_LOW.
  - WAIT_FV_LOW: S1 fval=0 moves to WAIT_FV_HIGH. This prevents capture of a partial frame.
  - WAIT_FV_HIGH: rising edge of S1 fval moves to CAPTURE.
  - CAPTURE: falling edge of S1 fval moves to END.
  - END (1 cycle): moves to WAIT_FV_HIGH if `cfg_continuous`=1 and no stop is pending; otherwise moves to IDLE.
- Hold register H (data, sof flag, full flag):
  - A valid pixel arriving with H full emits H with tlast=0, then loads the new pixel.
  - An S1 lval falling edge with H full emits H with tlast=1 and clears H.
  - An S1 fval falling edge is treated as an lval falling edge.
  - The first pixel after entering CAPTURE carries sof, which produces `m_tuser`.
- Outputs `m_*` are registered. `m_tvalid` is high exactly 1 cycle per emitted pixel. There is no buffering.
  - If `m_tvalid`=1 and `m_tready`=0, set `st_overflow`. The beat is still counted and is lost to the sink.
- Line pixel counter:
  - Increments on each valid pixel and saturates at 2^CNT_W−1.
  - Is compared at each line end (when `cfg_width`≠0) and then cleared.
- Line counter increments at each line end that had ≥1 pixel. Empty lines are not counted.
- In END:
  - Latch `st_width` and `st_height`.
  - Check height (when `cfg_height`≠0).
  - Pulse `st_frame_done` and increment `st_frame_cnt`.
- `cfg_stop`:
  - In WAIT_FV_LOW or WAIT_FV_HIGH: go to IDLE on the next cycle.
  - In CAPTURE: set stop-pending. The frame completes, then the FSM goes to IDLE.
- `cfg_start` is ignored when not in IDLE. If `cfg_start` and `cfg_stop` are asserted in the same cycle, stop wins and the FSM stays IDLE.
- `cfg_start` accepted in IDLE clears the sticky bits. Pending-stop is also cleared on exit to IDLE.
- `cfg_width`, `cfg_height` and `cfg_continuous` are sampled every cycle. Changing them mid-frame is legal; the check uses the current value.

## Timing
- Reset values:
  - FSM=IDLE, H empty.
  - All outputs 0 (`m_tdata`, `m_tvalid`, `m_tuser`, `m_tlast`, `st_*`).
  - All counters 0.
- Reset mid-frame aborts immediately. No `m_tlast` and no `st_frame_done` are produced.
- Latency with continuous dval: a pixel on `CL_data` before edge k appears on `m_*` after edge k+2.
- Line-end latency: the last pixel appears on `m_*` 2 edges after lval goes low on `CL_data`.
- With dval gaps, a pixel is held in H until the next valid pixel or the line end.
- `st_frame_done` rises 1 cycle after the S1 fval falling edge is detected. `st_*` values are stable from that cycle onward.
- `st_busy` falls in the cycle after END when the FSM exits to IDLE.

## Test plan
- **Reset:** drive `CL_rst` for 2 cycles while `CL_data` toggles and fval=1 → all outputs stay 0 and no `m_tvalid` appears; after release the block stays IDLE.
- **Single frame:** `cfg_start`, `cfg_width`=8, `cfg_height`=3; fval low for 4 cycles, then 3 lines of 8 pixels (data 1..24) with 4-cycle lval gaps → exactly 24 beats, each 2 cycles after its input; `m_tuser` only on data 1; `m_tlast` on 8, 16, 24; `st_frame_done` pulses once; `st_width`=8, `st_height`=3, `st_frame_cnt`=1; no errors.
- **Mid-frame arm:** `cfg_start` during line 2 of a frame → no beats until the next frame's fval rise; that frame is captured completely (24 beats).
- **Geometry and dval gaps:** line 2 has 7 pixels with dval low for 3 cycles mid-line; frame has 2 lines; `cfg_height`=3 → beats = valid pixels only, `m_tlast` on the 7th pixel of line 2; `st_err_width`=1, `st_err_height`=1, `st_height`=2.
- **Backpressure:** `m_tready`=0 for one beat → `st_overflow`=1 while beat count stays 24; the next accepted `cfg_start` clears it.
- **Continuous and stop:** `cfg_continuous`=1; 2 frames with `cfg_stop` in the middle of frame 2 → frame 2 completes, `st_frame_cnt`=2, `st_busy` falls after the second `st_frame_done`. A further `cfg_start` and `cfg_stop` in the same cycle → block remains IDLE.
